// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_prefetch
//  Brief    : Instruction prefetch queue fed by a synchronous instruction
//             memory, with redirect, halt and credit-based read issue.
//  Revision : 1.0
// ============================================================================
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [15:0]              mem_addr,
    output logic                     mem_req,
    input  logic [31:0]              mem_data,
    output logic [31:0]              instr,
    output logic [15:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    input  logic                     halt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_CR_W  = c_CNT_W + 1;

    logic [15:0]        r_fetch_pc;
    logic               r_inflight;
    logic [15:0]        r_inflight_pc;
    logic [15:0]        r_q_pc   [DEPTH];
    logic [31:0]        r_q_word [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_pop;
    logic               w_push;
    logic [c_CR_W-1:0]  w_credit;

    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid & instr_ready;
    assign w_push      = r_inflight;

    // Slots already committed (queued + in flight), less the one leaving now.
    assign w_credit = c_CR_W'(r_count) + c_CR_W'(r_inflight) - c_CR_W'(w_pop);

    assign mem_addr = r_fetch_pc;
    assign mem_req  = !reset && !redirect && !halt && (w_credit < c_CR_W'(DEPTH));

    assign instr    = instr_valid ? r_q_word[r_head] : 32'h0;
    assign instr_pc = instr_valid ? r_q_pc[r_head]   : 16'h0;
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 16'h0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= redirect_pc;
            r_inflight    <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= mem_req;
            if (mem_req) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 16'd1;
            end
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && !redirect && w_push) begin
            r_q_pc[r_tail]   <= r_inflight_pc;
            r_q_word[r_tail] <= mem_data;
        end
    end

endmodule
`default_nettype wire
